// File: rtl/rr_mux_arbiter_4.sv
// rtl/rr_mux_arbiter_4.sv - round-robin arbiter with hold limit driving a registered 4:1 data mux
module rr_mux_arbiter_4 #(
   parameter int DATA_W   = 8,
   parameter int MAX_HOLD = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [3:0]        req,
   input  logic [DATA_W-1:0] a,
   input  logic [DATA_W-1:0] b,
   input  logic [DATA_W-1:0] c,
   input  logic [DATA_W-1:0] d,
   output logic [3:0]        gnt,
   output logic              s1,
   output logic              s0,
   output logic [DATA_W-1:0] dout,
   output logic              dout_valid,
   output logic              busy
);

   localparam int HW = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
   localparam logic [HW-1:0] HOLD_LAST = HW'(MAX_HOLD - 1);

   typedef enum logic {IDLE, OWN} state_t;

   state_t            state_q, state_d;
   logic [3:0]        gnt_q, gnt_d;
   logic [1:0]        sel_q, sel_d;
   logic [1:0]        ptr_q, ptr_d;
   logic [HW-1:0]     hold_cnt_q, hold_cnt_d;
   logic [DATA_W-1:0] dout_q, dout_d;
   logic              dout_valid_q, dout_valid_d;

   logic [1:0]        scan_idx;
   logic [1:0]        pick_idx;
   logic              pick_found;
   logic              release_own;
   logic [DATA_W-1:0] mux_data;

   always_comb begin
      scan_idx   = '0;
      pick_idx   = '0;
      pick_found = 1'b0;
      // While owning, ptr_q is owner+1, so the current owner is scanned last.
      for (int i = 0; i < 4; i++) begin
         scan_idx = ptr_q + i[1:0];
         if (!pick_found && req[scan_idx]) begin
            pick_found = 1'b1;
            pick_idx   = scan_idx;
         end
      end
   end

   always_comb begin
      case (sel_q)
         2'd0:    mux_data = a;
         2'd1:    mux_data = b;
         2'd2:    mux_data = c;
         default: mux_data = d;
      endcase
   end

   assign release_own = !req[sel_q] || (hold_cnt_q == HOLD_LAST);

   always_comb begin
      state_d      = state_q;
      gnt_d        = gnt_q;
      sel_d        = sel_q;
      ptr_d        = ptr_q;
      hold_cnt_d   = hold_cnt_q;
      dout_d       = dout_q;
      dout_valid_d = 1'b0;

      if (state_q == OWN) begin
         dout_d       = mux_data;
         dout_valid_d = 1'b1;
      end

      if (state_q == OWN && !release_own) begin
         hold_cnt_d = hold_cnt_q + 1'b1;
      end else if (pick_found) begin
         state_d    = OWN;
         gnt_d      = 4'b0001 << pick_idx;
         sel_d      = pick_idx;
         ptr_d      = pick_idx + 2'd1;
         hold_cnt_d = '0;
      end else begin
         // No requester left: drop grant but keep the last select.
         state_d    = IDLE;
         gnt_d      = '0;
         hold_cnt_d = '0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         gnt_q        <= '0;
         sel_q        <= '0;
         ptr_q        <= '0;
         hold_cnt_q   <= '0;
         dout_q       <= '0;
         dout_valid_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         gnt_q        <= gnt_d;
         sel_q        <= sel_d;
         ptr_q        <= ptr_d;
         hold_cnt_q   <= hold_cnt_d;
         dout_q       <= dout_d;
         dout_valid_q <= dout_valid_d;
      end
   end

   assign gnt        = gnt_q;
   assign s1         = sel_q[1];
   assign s0         = sel_q[0];
   assign dout       = dout_q;
   assign dout_valid = dout_valid_q;
   assign busy       = |gnt_q;

endmodule

// File: tb/tb_rr_mux_arbiter_4.sv
// tb/tb_rr_mux_arbiter_4.sv - randomized self-checking bench for rr_mux_arbiter_4
module tb_rr_mux_arbiter_4;

   localparam int DATA_W   = 8;
   localparam int MAX_HOLD = 4;

   logic              clk;
   logic              rst_n;
   logic [3:0]        req;
   logic [DATA_W-1:0] a, b, c, d;
   logic [3:0]        gnt;
   logic              s1, s0;
   logic [DATA_W-1:0] dout;
   logic              dout_valid;
   logic              busy;

   int n_checks;
   int n_errors;

   // Reference model: owner index (-1 = nobody), cycles already held, next priority.
   int                m_owner;
   int                m_cnt;
   int                m_ptr;
   int                m_sel;
   logic [DATA_W-1:0] m_dout;
   logic              m_valid;
   logic [15:0]       exp_vec;

   rr_mux_arbiter_4 #(.DATA_W(DATA_W), .MAX_HOLD(MAX_HOLD)) dut (
      .clk(clk), .rst_n(rst_n), .req(req),
      .a(a), .b(b), .c(c), .d(d),
      .gnt(gnt), .s1(s1), .s0(s0), .dout(dout),
      .dout_valid(dout_valid), .busy(busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [15:0] obs_vec();
      return {gnt, s1, s0, dout, dout_valid, busy};
   endfunction

   task automatic model_reset();
      m_owner = -1; m_cnt = 0; m_ptr = 0; m_sel = 0;
      m_dout = '0; m_valid = 1'b0;
      exp_vec = '0;
   endtask

   task automatic rand_data();
      a = DATA_W'($urandom); b = DATA_W'($urandom);
      c = DATA_W'($urandom); d = DATA_W'($urandom);
   endtask

   // Drive req, take one clock edge, advance the model on the sampled inputs.
   task automatic tick(input logic [3:0] r);
      logic [DATA_W-1:0] din [4];
      int                found;
      req = r;
      @(posedge clk);
      din[0] = a; din[1] = b; din[2] = c; din[3] = d;
      if (m_owner >= 0) m_dout = din[m_sel];
      m_valid = (m_owner >= 0);
      if (m_owner >= 0 && r[m_owner] && m_cnt < MAX_HOLD - 1) begin
         m_cnt = m_cnt + 1;
      end else begin
         found = -1;
         for (int k = 0; k < 4; k++)
            if (found < 0 && r[(m_ptr + k) % 4]) found = (m_ptr + k) % 4;
         m_cnt = 0;
         if (found >= 0) begin
            m_owner = found;
            m_sel   = found;
            m_ptr   = (found + 1) % 4;
         end else begin
            m_owner = -1;
         end
      end
      exp_vec = {(m_owner < 0) ? 4'b0000 : 4'(1 << m_owner), 2'(m_sel),
                 m_dout, m_valid, (m_owner >= 0)};
      #1;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      req   = '0;
      #2;
      model_reset();
      rst_n = 1'b1;
      #1;
   endtask

   task automatic test_reset();
      #1;
      n_checks++;
      if (obs_vec() !== 16'h0) begin
         n_errors++; $display("FAIL reset_initial: got %h want %h", obs_vec(), 16'h0);
      end
      rst_n = 1'b1;
      #1;
      rand_data();
      tick(4'b0100);
      tick(4'b0100);
      n_checks++;
      if (gnt !== 4'b0100) begin
         n_errors++; $display("FAIL reset_pregrant: gnt got %b want %b", gnt, 4'b0100);
      end
      #2;
      rst_n = 1'b0;
      #1;
      n_checks++;
      if (obs_vec() !== 16'h0) begin
         n_errors++; $display("FAIL reset_async: got %h want %h", obs_vec(), 16'h0);
      end
      model_reset();
      req   = '0;
      rst_n = 1'b1;
      tick(4'b0000);
      n_checks++;
      if (obs_vec() !== exp_vec) begin
         n_errors++; $display("FAIL reset_release: got %h want %h", obs_vec(), exp_vec);
      end
   endtask

   task automatic test_single();
      do_reset();
      rand_data();
      b = 8'h5A;
      tick(4'b0010);
      n_checks++;
      if (gnt !== 4'b0010 || {s1, s0} !== 2'b01 || dout_valid !== 1'b0) begin
         n_errors++;
         $display("FAIL single_grant: gnt=%b s=%b%b v=%b want 0010 01 0", gnt, s1, s0, dout_valid);
      end
      tick(4'b0010);
      n_checks++;
      if (dout !== 8'h5A || dout_valid !== 1'b1) begin
         n_errors++; $display("FAIL single_data: dout=%h v=%b want 5a 1", dout, dout_valid);
      end
      n_checks++;
      if (obs_vec() !== exp_vec) begin
         n_errors++; $display("FAIL single_model: got %h want %h", obs_vec(), exp_vec);
      end
   endtask

   task automatic test_fairness();
      int own;
      do_reset();
      for (int n = 1; n <= 40; n++) begin
         rand_data();
         tick(4'b1111);
         own = ((n - 1) / MAX_HOLD) % 4;
         n_checks++;
         if (gnt !== 4'(1 << own) || {s1, s0} !== 2'(own)) begin
            n_errors++;
            $display("FAIL fairness cycle %0d: gnt=%b s=%b%b want owner %0d", n, gnt, s1, s0, own);
         end
         n_checks++;
         if (obs_vec() !== exp_vec) begin
            n_errors++; $display("FAIL fairness_model cycle %0d: got %h want %h", n, obs_vec(), exp_vec);
         end
      end
   endtask

   task automatic test_early_drop();
      do_reset();
      rand_data();
      tick(4'b0001);
      tick(4'b0001);
      tick(4'b0110);
      n_checks++;
      if (gnt !== 4'b0010) begin
         n_errors++; $display("FAIL early_drop_b: gnt got %b want %b", gnt, 4'b0010);
      end
      for (int n = 0; n < 4; n++) begin
         rand_data();
         tick(4'b0110);
      end
      n_checks++;
      if (gnt !== 4'b0100 || obs_vec() !== exp_vec) begin
         n_errors++; $display("FAIL early_drop_c: gnt got %b want %b (vec %h/%h)", gnt, 4'b0100, obs_vec(), exp_vec);
      end
   endtask

   task automatic test_hog();
      do_reset();
      for (int n = 0; n < 12; n++) begin
         rand_data();
         tick(4'b1000);
         n_checks++;
         if (gnt !== 4'b1000 || {s1, s0} !== 2'b11 || obs_vec() !== exp_vec) begin
            n_errors++;
            $display("FAIL hog cycle %0d: got %h want %h", n, obs_vec(), exp_vec);
         end
      end
   endtask

   task automatic test_idle();
      tick(4'b0000);
      n_checks++;
      if (gnt !== 4'b0000 || busy !== 1'b0 || dout_valid !== 1'b1 || {s1, s0} !== 2'b11) begin
         n_errors++;
         $display("FAIL idle_drop: gnt=%b busy=%b v=%b s=%b%b want 0000 0 1 11", gnt, busy, dout_valid, s1, s0);
      end
      tick(4'b0000);
      n_checks++;
      if (dout_valid !== 1'b0 || obs_vec() !== exp_vec) begin
         n_errors++; $display("FAIL idle_valid: got %h want %h", obs_vec(), exp_vec);
      end
      tick(4'b0001);
      n_checks++;
      if (gnt !== 4'b0001 || {s1, s0} !== 2'b00) begin
         n_errors++; $display("FAIL idle_regrant: gnt=%b s=%b%b want 0001 00", gnt, s1, s0);
      end
   endtask

   task automatic test_random();
      logic [3:0] r;
      do_reset();
      r = '0;
      for (int n = 0; n < 500; n++) begin
         rand_data();
         if ($urandom_range(0, 3) == 0) r = 4'($urandom);
         tick(r);
         n_checks++;
         if (obs_vec() !== exp_vec) begin
            n_errors++; $display("FAIL random cycle %0d req=%b: got %h want %h", n, r, obs_vec(), exp_vec);
         end
      end
   endtask

   initial begin
      n_checks = 0;
      n_errors = 0;
      rst_n    = 1'b0;
      req      = '0;
      a = '0; b = '0; c = '0; d = '0;
      model_reset();
      test_reset();
      test_single();
      test_fairness();
      test_early_drop();
      test_hog();
      test_idle();
      test_random();
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
